// File: rtl/program_loader_if.sv
// program_loader_if: UART byte stream in, program-memory write port and core control out
interface program_loader_if #(
    parameter int MEM_WORDS = 256
);
    localparam int WW = $clog2(MEM_WORDS + 1);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          mem_sel;
    logic          mem_write_enable;
    logic [31:0]   mem_address;
    logic [31:0]   mem_write_data;
    logic          cpu_run;
    logic          load_done;
    logic          load_error;
    logic [WW-1:0] words_loaded;
    modport master (
        input  rx_data, rx_valid,
        output mem_sel, mem_write_enable, mem_address, mem_write_data,
        output cpu_run, load_done, load_error, words_loaded
    );
    modport slave (
        output rx_data, rx_valid,
        input  mem_sel, mem_write_enable, mem_address, mem_write_data,
        input  cpu_run, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: UART boot loader that writes little-endian words into program memory
module program_loader #(
    parameter logic [7:0] MAGIC          = 8'hA5,
    parameter int         MEM_WORDS      = 256,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic              clk,
    input logic              reset_n,
    program_loader_if.master bus
);
    localparam int WW = $clog2(MEM_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHECK, DONE, ERROR} state_t;

    state_t        state, state_n;
    logic [31:0]   len, len_n, word, word_n;
    logic [1:0]    idx, idx_n;
    logic [7:0]    csum, csum_n;
    logic [TW-1:0] idle, idle_n;
    logic          mem_sel, mem_sel_n, we, we_n, cpu_run, cpu_run_n;
    logic          done, done_n, err, err_n;
    logic [31:0]   addr, addr_n, wdata, wdata_n;
    logic [WW-1:0] wl, wl_n;
    logic          active, timeout, go_err;

    assign bus.mem_sel          = mem_sel;
    assign bus.mem_write_enable = we;
    assign bus.mem_address      = addr;
    assign bus.mem_write_data   = wdata;
    assign bus.cpu_run          = cpu_run;
    assign bus.load_done        = done;
    assign bus.load_error       = err;
    assign bus.words_loaded     = wl;

    // Next-state and next-output computation; every output leaves through a register
    always_comb begin
        state_n   = state;
        len_n     = len;
        word_n    = word;
        idx_n     = idx;
        csum_n    = csum;
        mem_sel_n = mem_sel;
        we_n      = 1'b0;
        cpu_run_n = cpu_run;
        done_n    = 1'b0;
        err_n     = err;
        addr_n    = addr;
        wdata_n   = wdata;
        wl_n      = wl;
        go_err    = 1'b0;
        active    = state inside {LEN, DATA, CHECK};
        idle_n    = (!active || bus.rx_valid) ? '0 : idle + 1'b1;
        timeout   = active && !bus.rx_valid && idle == TW'(TIMEOUT_CYCLES - 1);
        if (bus.rx_valid) begin
            case (state)
                IDLE, ERROR: if (bus.rx_data == MAGIC) begin
                    state_n   = LEN;
                    cpu_run_n = 1'b0;
                    mem_sel_n = 1'b1;
                    err_n     = 1'b0;
                    wl_n      = '0;
                    idx_n     = '0;
                    csum_n    = '0;
                end
                LEN: begin
                    len_n = {bus.rx_data, len[31:8]};
                    idx_n = idx + 1'b1;
                    if (idx == 2'd3) begin
                        if (len_n == '0 || len_n > 32'(MEM_WORDS)) go_err = 1'b1;
                        else state_n = DATA;
                    end
                end
                DATA: begin
                    word_n = {bus.rx_data, word[31:8]};
                    csum_n = csum ^ bus.rx_data;
                    idx_n  = idx + 1'b1;
                    if (idx == 2'd3) begin
                        we_n    = 1'b1;
                        addr_n  = 32'(wl) << 2;
                        wdata_n = word_n;
                        wl_n    = wl + 1'b1;
                        if (wl_n == WW'(len)) state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (bus.rx_data == csum) begin
                        state_n   = DONE;
                        done_n    = 1'b1;
                        mem_sel_n = 1'b0;
                    end else go_err = 1'b1;
                end
                default: ;
            endcase
        end
        if (state == DONE) begin
            state_n   = IDLE;
            cpu_run_n = 1'b1;
        end
        if (timeout || go_err) begin
            state_n   = ERROR;
            err_n     = 1'b1;
            mem_sel_n = 1'b0;
        end
    end

    // State and output registers; reset hands memory back to the PC and lets the core run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            len     <= '0;
            word    <= '0;
            idx     <= '0;
            csum    <= '0;
            idle    <= '0;
            mem_sel <= 1'b0;
            we      <= 1'b0;
            cpu_run <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            wl      <= '0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            word    <= word_n;
            idx     <= idx_n;
            csum    <= csum_n;
            idle    <= idle_n;
            mem_sel <= mem_sel_n;
            we      <= we_n;
            cpu_run <= cpu_run_n;
            done    <= done_n;
            err     <= err_n;
            addr    <= addr_n;
            wdata   <= wdata_n;
            wl      <= wl_n;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vector bench for the UART program loader
module tb_program_loader;
    localparam int MW = 256;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [4:0]  f;
        logic [8:0]  wl;
        logic [31:0] a;
        logic [31:0] w;
    } vec_t;

    localparam logic [7:0] NORM [13] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                                         8'h93, 8'h00, 8'h50, 8'h00,
                                         8'h13, 8'h01, 8'hA0, 8'h00};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int nchk = 0;
    int nfail = 0;
    int ndone = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    vec_t tbl[16];

    program_loader_if #(.MEM_WORDS(MW)) bus ();

    program_loader #(.MAGIC(8'hA5), .MEM_WORDS(MW), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.cpu_run, bus.mem_sel, bus.mem_write_enable, bus.load_done, bus.load_error};
    endfunction

    // Log every write and load_done pulse away from the active edge
    always @(negedge clk) begin
        if (bus.load_done) ndone++;
        if (bus.mem_write_enable) begin
            wa.push_back(bus.mem_address);
            wd.push_back(bus.mem_write_data);
            check("sel_during_write", 64'(bus.mem_sel), 64'd1);
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] last);
        for (int i = 0; i < 13; i++) step(1'b1, NORM[i]);
        step(1'b1, last);
    endtask

    task automatic check_writes(input string name);
        check({name, "_count"}, 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            check({name, "_a0"}, 64'(wa[0]), 64'h0);
            check({name, "_d0"}, 64'(wd[0]), 64'h00500093);
            check({name, "_a1"}, 64'(wa[1]), 64'h4);
            check({name, "_d1"}, 64'(wd[1]), 64'h00A00113);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 8'h02, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 8'h00, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 8'h00, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 8'h00, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[5]  = '{1'b1, 8'h93, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 8'h00, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[7]  = '{1'b1, 8'h50, 5'b01000, 9'd0, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 8'h00, 5'b01100, 9'd1, 32'h0, 32'h00500093};
        tbl[9]  = '{1'b1, 8'h13, 5'b01000, 9'd1, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 8'h01, 5'b01000, 9'd1, 32'h0, 32'h0};
        tbl[11] = '{1'b1, 8'hA0, 5'b01000, 9'd1, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 8'h00, 5'b01100, 9'd2, 32'h4, 32'h00A00113};
        tbl[13] = '{1'b1, 8'h71, 5'b00010, 9'd2, 32'h0, 32'h0};
        tbl[14] = '{1'b0, 8'h00, 5'b10000, 9'd2, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 8'h00, 5'b10000, 9'd2, 32'h0, 32'h0};
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 64'(flags()), 64'b10000);
        check("reset_addr", 64'(bus.mem_address), 64'h0);
        check("reset_data", 64'(bus.mem_write_data), 64'h0);
        check("reset_wl", 64'(bus.words_loaded), 64'h0);
        reset_n = 1'b1;
        step(1'b0, 8'h00);

        step(1'b1, 8'h00);
        check("idle_00", 64'(flags()), 64'b10000);
        step(1'b1, 8'hFF);
        check("idle_ff", 64'(flags()), 64'b10000);
        step(1'b1, 8'h5A);
        check("idle_5a", 64'(flags()), 64'b10000);
        step(1'b0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(tbl[i].f));
            check($sformatf("vec%0d_wl", i), 64'(bus.words_loaded), 64'(tbl[i].wl));
            if (tbl[i].f[2]) begin
                check($sformatf("vec%0d_addr", i), 64'(bus.mem_address), 64'(tbl[i].a));
                check($sformatf("vec%0d_data", i), 64'(bus.mem_write_data), 64'(tbl[i].w));
            end
        end
        check_writes("normal");
        check("normal_done_pulses", 64'(ndone), 64'd1);

        wa.delete();
        wd.delete();
        ndone = 0;
        send_load(8'h70);
        check("badsum_flags", 64'(flags()), 64'b00001);
        step(1'b0, 8'h00);
        check("badsum_hold", 64'(flags()), 64'b00001);
        check_writes("badsum");
        wa.delete();
        wd.delete();
        step(1'b1, 8'hA5);
        check("resend_magic", 64'(flags()), 64'b01000);
        for (int i = 1; i < 13; i++) step(1'b1, NORM[i]);
        step(1'b1, 8'h71);
        check("resend_done", 64'(flags()), 64'b00010);
        step(1'b0, 8'h00);
        check("resend_run", 64'(flags()), 64'b10000);
        check_writes("resend");
        check("resend_done_pulses", 64'(ndone), 64'd1);

        wa.delete();
        wd.delete();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        check("len0_before", 64'(flags()), 64'b01000);
        step(1'b1, 8'h00);
        check("len0_error", 64'(flags()), 64'b00001);
        step(1'b1, 8'hA5);
        check("len257_magic", 64'(flags()), 64'b01000);
        step(1'b1, 8'h01);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        check("len257_error", 64'(flags()), 64'b00001);
        step(1'b0, 8'h00);
        check("len_no_writes", 64'(wa.size()), 64'd0);

        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        repeat (99) step(1'b0, 8'h00);
        check("timeout_99", 64'(flags()), 64'b01000);
        step(1'b0, 8'h00);
        check("timeout_100", 64'(flags()), 64'b00001);
        check("timeout_no_writes", 64'(wa.size()), 64'd0);

        for (int i = 0; i < 9; i++) step(1'b1, NORM[i] ^ ((i > 4) ? 8'h5C : 8'h00));
        step(1'b1, 8'h55);
        check("midload_flags", 64'(flags()), 64'b01000);
        check("midload_wl", 64'(bus.words_loaded), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_flags", 64'(flags()), 64'b10000);
        check("areset_addr", 64'(bus.mem_address), 64'h0);
        check("areset_data", 64'(bus.mem_write_data), 64'h0);
        check("areset_wl", 64'(bus.words_loaded), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wa.delete();
        wd.delete();
        ndone = 0;
        send_load(8'h71);
        step(1'b0, 8'h00);
        check("fresh_flags", 64'(flags()), 64'b10000);
        check("fresh_wl", 64'(bus.words_loaded), 64'd2);
        check_writes("fresh");
        check("fresh_done_pulses", 64'(ndone), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
